// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: bundle between the five-stage pipeline and its stall/redirect
// controller.
//   master : pipeline side. Drives the per-stage stall requests and the EX
//            branch pulse. Receives the stall vector, the PC redirect,
//            the flush and the stall monitors.
//   slave  : controller side (pipe_ctrl).
interface pipe_ctrl_if;
  logic        stallreq_if_i;
  logic        stallreq_id_i;
  logic        stallreq_ex_i;
  logic        stallreq_mem_i;
  logic        ex_branch_flag_i;
  logic [31:0] ex_branch_addr_i;
  logic [4:0]  stalled;
  logic        pc_jump_flag_o;
  logic [31:0] pc_jump_addr_o;
  logic        flush_o;
  logic        stall_timeout_o;
  logic [31:0] stall_cycles_o;

  modport master (
    output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    output ex_branch_flag_i, ex_branch_addr_i,
    input  stalled, pc_jump_flag_o, pc_jump_addr_o, flush_o,
    input  stall_timeout_o, stall_cycles_o
  );

  modport slave (
    input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    input  ex_branch_flag_i, ex_branch_addr_i,
    output stalled, pc_jump_flag_o, pc_jump_addr_o, flush_o,
    output stall_timeout_o, stall_cycles_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/redirect controller for the five-stage core.
//   - Combines per-stage stall requests into the stalled[4:0] hold vector
//     (priority mem > ex > id > if; bit 0 = PC ... bit 4 = MEM/WB).
//   - Applies EX branch redirects immediately when the PC is free. Otherwise
//     it parks the target until the PC stage unfreezes, flushing IF/ID
//     meanwhile.
//   - Tracks the current stall run (timeout flag) and the total stalled cycles.
// Ports:
//   clk  : core clock
//   rst  : asynchronous active-low reset
//   bus  : pipe_ctrl_if.slave (requests/branch in; stall, redirect, flush,
//          monitors out)
module pipe_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic {IDLE, PENDING} state_e;

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT_CYCLES);

  state_e           state_q, state_d;
  logic [31:0]      pend_addr_q, pend_addr_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic             timeout_q, timeout_d;
  logic [31:0]      cycles_q, cycles_d;

  logic [4:0]  stall_req;
  logic        stall_any;
  logic        branch_ok;
  logic        jump;
  logic [31:0] jump_addr;
  logic        flush;

  // Stall vector: every stage upstream of the requester holds as well.
  always_comb begin
    if (bus.stallreq_mem_i)     stall_req = 5'b11111;
    else if (bus.stallreq_ex_i) stall_req = 5'b01111;
    else if (bus.stallreq_id_i) stall_req = 5'b00111;
    else if (bus.stallreq_if_i) stall_req = 5'b00011;
    else                        stall_req = 5'b00000;
  end

  assign stall_any = |stall_req;
  // While EX/MEM is held, the EX stage is not really executing, so a branch
  // pulse seen then is not genuine.
  assign branch_ok = bus.ex_branch_flag_i & ~stall_req[3];

  // NOTE: every variable gets a default at the top of the block so that no
  // path leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    jump        = 1'b0;
    jump_addr   = 32'h0;
    flush       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (branch_ok) begin
          flush = 1'b1;
          if (!stall_req[0]) begin
            jump      = 1'b1;
            jump_addr = bus.ex_branch_addr_i;
          end else begin
            pend_addr_d = bus.ex_branch_addr_i;
            state_d     = PENDING;
          end
        end
      end
      PENDING: begin
        // The wrong-path fetch keeps entering IF/ID until the redirect lands.
        flush = 1'b1;
        // A second branch here is not expected; the newest target wins.
        if (!stall_req[0]) begin
          jump      = 1'b1;
          jump_addr = branch_ok ? bus.ex_branch_addr_i : pend_addr_q;
          state_d   = IDLE;
        end else if (branch_ok) begin
          pend_addr_d = bus.ex_branch_addr_i;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall monitors: run length saturates at the timeout value, so it never wraps.
  always_comb begin
    run_cnt_d = '0;
    cycles_d  = cycles_q;
    if (stall_any) begin
      run_cnt_d = (run_cnt_q == TimeoutVal) ? run_cnt_q : run_cnt_q + 1'b1;
      cycles_d  = cycles_q + 32'd1;
    end
    timeout_d = (run_cnt_d == TimeoutVal);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pend_addr_q <= 32'h0;
      run_cnt_q   <= '0;
      timeout_q   <= 1'b0;
      cycles_q    <= 32'h0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      run_cnt_q   <= run_cnt_d;
      timeout_q   <= timeout_d;
      cycles_q    <= cycles_d;
    end
  end

  // NOTE: the combinational outputs are gated by rst as well, because the
  // registers alone cannot hold an input-driven path low during reset.
  assign bus.stalled         = rst ? stall_req : 5'b00000;
  assign bus.pc_jump_flag_o  = rst & jump;
  assign bus.pc_jump_addr_o  = rst ? jump_addr : 32'h0;
  assign bus.flush_o         = rst & flush;
  assign bus.stall_timeout_o = timeout_q;
  assign bus.stall_cycles_o  = cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scoreboard bench for pipe_ctrl (TIMEOUT_CYCLES = 4).
// The driver applies one vector per cycle just after the rising edge and
// queues the expected outputs for that cycle. The monitor pops and compares
// on the falling edge.
module tb_pipe_ctrl;

  logic clk;
  logic rst;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  stalled;
    logic        jump;
    logic [31:0] addr;
    logic        flush;
    logic        tmo;
    logic [31:0] cyc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one queued expectation per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".stalled"}, 32'(bus.stalled),         32'(e.stalled));
        check({e.name, ".jump"},    32'(bus.pc_jump_flag_o),  32'(e.jump));
        check({e.name, ".addr"},    bus.pc_jump_addr_o,       e.addr);
        check({e.name, ".flush"},   32'(bus.flush_o),         32'(e.flush));
        check({e.name, ".timeout"}, 32'(bus.stall_timeout_o), 32'(e.tmo));
        check({e.name, ".cycles"},  bus.stall_cycles_o,       e.cyc);
      end
    end
  end

  // req = {mem, ex, id, if}
  task automatic step(input string name, input logic rst_v, input logic [3:0] req,
                      input logic br, input logic [31:0] ba,
                      input logic [4:0] e_st, input logic e_j, input logic [31:0] e_a,
                      input logic e_f, input logic e_to, input logic [31:0] e_cyc);
    exp_t e;
    rst                  = rst_v;
    bus.stallreq_mem_i   = req[3];
    bus.stallreq_ex_i    = req[2];
    bus.stallreq_id_i    = req[1];
    bus.stallreq_if_i    = req[0];
    bus.ex_branch_flag_i = br;
    bus.ex_branch_addr_i = ba;
    e.name = name; e.stalled = e_st; e.jump = e_j; e.addr = e_a;
    e.flush = e_f; e.tmo = e_to; e.cyc = e_cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset forces everything to zero even with live requests and a branch.
    step("rst0",     1'b0, 4'b1000, 1'b1, 32'hDEAD, 5'b00000, 0, 32'h0,   0, 0, 0);
    step("rst1",     1'b0, 4'b0011, 1'b1, 32'hBEEF, 5'b00000, 0, 32'h0,   0, 0, 0);
    // Priority
    step("prio_idm", 1'b1, 4'b1010, 1'b0, 32'h0,    5'b11111, 0, 32'h0,   0, 0, 0);
    step("prio_id",  1'b1, 4'b0010, 1'b0, 32'h0,    5'b00111, 0, 32'h0,   0, 0, 1);
    step("prio_no",  1'b1, 4'b0000, 1'b0, 32'h0,    5'b00000, 0, 32'h0,   0, 0, 2);
    // Unstalled branch: same-cycle redirect, gone next cycle
    step("br_now",   1'b1, 4'b0000, 1'b1, 32'h100,  5'b00000, 1, 32'h100, 1, 0, 2);
    step("br_after", 1'b1, 4'b0000, 1'b0, 32'h0,    5'b00000, 0, 32'h0,   0, 0, 2);
    // Pending redirect behind an IF stall
    step("pend0",    1'b1, 4'b0001, 1'b1, 32'h200,  5'b00011, 0, 32'h0,   1, 0, 2);
    step("pend1",    1'b1, 4'b0001, 1'b0, 32'h0,    5'b00011, 0, 32'h0,   1, 0, 3);
    step("pend2",    1'b1, 4'b0001, 1'b0, 32'h0,    5'b00011, 0, 32'h0,   1, 0, 4);
    step("pend_fire",1'b1, 4'b0000, 1'b0, 32'h0,    5'b00000, 1, 32'h200, 1, 0, 5);
    step("pend_idle",1'b1, 4'b0000, 1'b0, 32'h0,    5'b00000, 0, 32'h0,   0, 0, 5);
    // Timeout: EX stall for 6 cycles (total cycles 5 -> 11), ignored branch in the 5th
    step("to1",      1'b1, 4'b0100, 1'b0, 32'h0,    5'b01111, 0, 32'h0,   0, 0, 5);
    step("to2",      1'b1, 4'b0100, 1'b0, 32'h0,    5'b01111, 0, 32'h0,   0, 0, 6);
    step("to3",      1'b1, 4'b0100, 1'b0, 32'h0,    5'b01111, 0, 32'h0,   0, 0, 7);
    step("to4",      1'b1, 4'b0100, 1'b0, 32'h0,    5'b01111, 0, 32'h0,   0, 0, 8);
    step("to5_ign",  1'b1, 4'b0100, 1'b1, 32'h300,  5'b01111, 0, 32'h0,   0, 1, 9);
    step("to6",      1'b1, 4'b0100, 1'b0, 32'h0,    5'b01111, 0, 32'h0,   0, 1, 10);
    step("to_rel",   1'b1, 4'b0000, 1'b0, 32'h0,    5'b00000, 0, 32'h0,   0, 1, 11);
    step("to_clr",   1'b1, 4'b0000, 1'b0, 32'h0,    5'b00000, 0, 32'h0,   0, 0, 11);
    // Newest pending target wins
    step("nw0",      1'b1, 4'b0010, 1'b1, 32'h400,  5'b00111, 0, 32'h0,   1, 0, 11);
    step("nw1",      1'b1, 4'b0010, 1'b1, 32'h500,  5'b00111, 0, 32'h0,   1, 0, 12);
    step("nw_fire",  1'b1, 4'b0000, 1'b0, 32'h0,    5'b00000, 1, 32'h500, 1, 0, 13);
    step("nw_idle",  1'b1, 4'b0000, 1'b0, 32'h0,    5'b00000, 0, 32'h0,   0, 0, 13);
    // Reset while PENDING discards the redirect
    step("rp_pend",  1'b1, 4'b0001, 1'b1, 32'h600,  5'b00011, 0, 32'h0,   1, 0, 13);
    step("rp_rst",   1'b0, 4'b0001, 1'b0, 32'h0,    5'b00000, 0, 32'h0,   0, 0, 0);
    step("rp_rel0",  1'b1, 4'b0000, 1'b0, 32'h0,    5'b00000, 0, 32'h0,   0, 0, 0);
    step("rp_rel1",  1'b1, 4'b0000, 1'b0, 32'h0,    5'b00000, 0, 32'h0,   0, 0, 0);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline stall/redirect controller for the five-stage core: the producer of the `stalled[4:0]` vector that every pipeline register (`pc_reg`, `if_id`, `id_ex`, `ex_mem`, `mem_wb`) consumes, and of the PC redirect/flush triggered by branches resolved in EX. It prioritises per-stage stall requests and holds a branch redirect that arrives while the PC stage is frozen until it can be applied. It also monitors stall duration for debug and performance.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1024: consecutive stalled cycles after which `stall_timeout_o` asserts.
- `CNT_W`, 11: width of the consecutive-stall counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-low reset (`RstEnable` = 0).
- `stallreq_if_i`  in  1  instruction fetch bus wait.
- `stallreq_id_i`  in  1  load-use hazard in ID.
- `stallreq_ex_i`  in  1  multi-cycle EX op (divider) busy.
- `stallreq_mem_i`  in  1  data bus wait.
- `ex_branch_flag_i`  in  1  taken branch/jump resolved in EX (single-cycle pulse).
- `ex_branch_addr_i`  in  32  branch target.
- `stalled`  out  5  [0]=PC, [1]=IF/ID hold, [2]=ID/EX hold, [3]=EX/MEM hold, [4]=MEM/WB hold.
- `pc_jump_flag_o`  out  1  load `pc_jump_addr_o` into PC this cycle.
- `pc_jump_addr_o`  out  32  redirect target.
- `flush_o`  out  1  squash IF/ID contents.
- `stall_timeout_o`  out  1  registered; stall persisted ≥ TIMEOUT_CYCLES.
- `stall_cycles_o`  out  32  total cycles with `stalled != 0`.

## Operation
- `stalled` is combinational, priority mem > ex > id > if:
  - mem: 5'b11111
  - ex: 5'b01111
  - id: 5'b00111
  - if: 5'b00011
  - none: 5'b00000
- Effect on pipeline registers: the stage at the boundary (bit k set, bit k+1 clear) inserts a bubble downstream.
- Redirect FSM, states IDLE and PENDING; registers `pend_addr` (32 bits).
  - IDLE, branch pulse, `stalled[0]`=0: `pc_jump_flag_o`=1, `pc_jump_addr_o`=`ex_branch_addr_i`, `flush_o`=1 the same cycle. Stay in IDLE.
  - IDLE, branch pulse, `stalled[0]`=1: latch the address into `pend_addr`, assert `flush_o`, go to PENDING. `pc_jump_flag_o`=0.
  - PENDING: `flush_o`=1 every cycle. When `stalled[0]`=0: `pc_jump_flag_o`=1, `pc_jump_addr_o`=`pend_addr`, go to IDLE. Otherwise hold.
  - PENDING plus a new branch pulse: overwrite `pend_addr` with the new target (newest wins). This is illegal in normal flow but the behaviour is defined.
- `pc_jump_addr_o` = 0 whenever `pc_jump_flag_o`=0.
- Branch pulses are only honoured when `stalled[3]`=0. A pulse with `stalled[3]`=1 is ignored.
- Stall monitor:
  - `run_cnt` (CNT_W bits) increments each cycle `stalled != 0` and saturates at TIMEOUT_CYCLES. It clears to 0 on a cycle with `stalled` = 0.
  - `stall_timeout_o` is registered: 1 once `run_cnt` = TIMEOUT_CYCLES, cleared the cycle after `stalled` returns to 0.
  - `stall_cycles_o` increments each cycle `stalled != 0` and wraps modulo 2^32.

## Timing
- Reset (`rst`=0, asynchronous):
  - FSM to IDLE; `pend_addr`, `run_cnt`, `stall_cycles_o`, `stall_timeout_o` all 0.
  - `stalled` forced to 5'b00000, `pc_jump_flag_o`=0, `pc_jump_addr_o`=0, `flush_o`=0, regardless of inputs.
- Latency:
  - `stalled` follows requests with 0 cycles.
  - Unstalled redirect takes 0 cycles.
  - Pending redirect fires in the first cycle with `stalled[0]`=0.
- Reset asserted in PENDING: the pending redirect is discarded.
- Saturation: `run_cnt` never wraps; `stall_timeout_o` stays high while the stall persists.

## Test plan
- Priority: `stallreq_id_i`=1 and `stallreq_mem_i`=1 together -> `stalled`=5'b11111. Drop mem -> 5'b00111. Drop id -> 5'b00000.
- Unstalled branch: pulse with addr 0x0000_0100, no requests -> same cycle `pc_jump_flag_o`=1, addr 0x100, `flush_o`=1. Next cycle all three are 0.
- Pending redirect: `stallreq_if_i`=1 for 3 cycles, branch 0x200 in the first -> `pc_jump_flag_o`=0 and `flush_o`=1 for 3 cycles. In the cycle the request drops: jump=1, addr 0x200, then IDLE.
- Timeout with TIMEOUT_CYCLES=4: `stallreq_ex_i` held 6 cycles -> `stall_timeout_o` rises after the 4th stalled cycle and clears one cycle after release. `stall_cycles_o`=6.
- Ignored branch: pulse while `stallreq_ex_i`=1 -> no jump, no flush, FSM stays in IDLE.
- Reset mid-PENDING: `rst`=0 -> all outputs 0 immediately. After release with no requests, no jump occurs.
